// File: rtl/block_dispatch_cu_pkg.sv
// Shared definitions for the block dispatch control unit: FSM encoding,
// config word field offsets, default bus addresses and status bit positions.
package block_dispatch_cu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_CFG,
    ST_READ_CFG,
    ST_DISPATCH,
    ST_WAIT,
    ST_REQ_STAT,
    ST_READ_STAT,
    ST_WRITE_STAT
  } state_e;

  localparam int unsigned LAMBDA_LSB      = 0;
  localparam int unsigned GAMMA_LSB       = 8;
  localparam int unsigned MU_LSB          = 16;

  localparam int unsigned DEF_CONFIG_ADDR = 0;
  localparam int unsigned DEF_STATUS_ADDR = 1;

  localparam int unsigned STAT_DONE_BIT   = 0;
  localparam int unsigned STAT_ERR_BIT    = 1;

endpackage

// File: rtl/block_dispatch_cu_index_gen.sv
// Row/column walker over a Gamma x Mu block grid plus the remaining-block count.
module block_index_gen #(
  parameter int unsigned INDEX_WIDTH = 8,
  parameter int unsigned GREEK_SIZE  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    load_i,
  input  logic                    advance_i,
  input  logic [GREEK_SIZE-1:0]   gamma_i,
  input  logic [GREEK_SIZE-1:0]   mu_i,
  output logic [INDEX_WIDTH-1:0]  row_o,
  output logic [INDEX_WIDTH-1:0]  col_o,
  output logic [2*GREEK_SIZE-1:0] remaining_o
);

  localparam int unsigned NW = 2 * GREEK_SIZE;

  logic [GREEK_SIZE-1:0]  gamma_q, gamma_d;
  logic [INDEX_WIDTH-1:0] row_q, row_d, col_q, col_d;
  logic [NW-1:0]          rem_q, rem_d;
  logic                   row_last;

  assign row_last = (GREEK_SIZE'(row_q) == (gamma_q - GREEK_SIZE'(1)));

  always_comb begin
    gamma_d = gamma_q;
    row_d   = row_q;
    col_d   = col_q;
    rem_d   = rem_q;
    if (load_i) begin
      gamma_d = gamma_i;
      row_d   = '0;
      col_d   = '0;
      rem_d   = NW'(gamma_i) * NW'(mu_i);
    end else if (advance_i && (rem_q != '0)) begin
      rem_d = rem_q - NW'(1);
      if (row_last) begin
        row_d = '0;
        col_d = col_q + INDEX_WIDTH'(1);
      end else begin
        row_d = row_q + INDEX_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gamma_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      rem_q   <= '0;
    end else begin
      gamma_q <= gamma_d;
      row_q   <= row_d;
      col_q   <= col_d;
      rem_q   <= rem_d;
    end
  end

  assign row_o       = row_q;
  assign col_o       = col_q;
  assign remaining_o = rem_q;

endmodule

// File: rtl/block_dispatch_cu.sv
// Block dispatch control unit: reads a job config from memory, hands block
// indexes to P processing elements round by round, then writes back status.
module block_dispatch_cu
  import block_dispatch_cu_pkg::*;
#(
  parameter int unsigned P               = 4,
  parameter int unsigned INDEX_WIDTH     = 8,
  parameter int unsigned GREEK_SIZE      = 8,
  parameter int unsigned MEMORY_SIZE_LOG = 10,
  parameter int unsigned CONFIG_ADDR     = DEF_CONFIG_ADDR,
  parameter int unsigned STATUS_ADDR     = DEF_STATUS_ADDR
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset_n,
  input  logic                       i_Data_Ready,
  input  logic                       i_Grant,
  inout  logic [31:0]                io_Memory_Data,
  output logic                       o_Grant_Request,
  output logic [MEMORY_SIZE_LOG-1:0] o_Memory_Address,
  output logic                       o_Write_Enable,
  output logic [31:0]                o_Config,
  output logic [INDEX_WIDTH-1:0]     o_Row_Index,
  output logic [INDEX_WIDTH-1:0]     o_Column_Index,
  output logic [P-1:0]               o_Indexes_Ready,
  input  logic [P-1:0]               i_Indexes_Received,
  input  logic [P-1:0]               i_Result_Ready,
  output logic                       o_Busy,
  output logic                       o_Done
);

  localparam int unsigned KW = $clog2(P + 1);

  state_e                  state_q, state_d;
  logic                    rd_q, rd_d;
  logic [KW-1:0]           k_q, k_d;
  logic [P-1:0]            mask_q, mask_d;
  logic [31:0]             cfg_q, cfg_d, stat_q, stat_d;
  logic                    err_q, err_d, done_q, done_d;

  logic [GREEK_SIZE-1:0]   gamma, mu;
  logic                    cfg_err, cfg_capture, round_end, accept, all_ready;
  logic [P-1:0]            ready_vec;
  logic [2*GREEK_SIZE-1:0] remaining;
  logic [31:0]             stat_word;

  assign gamma       = io_Memory_Data[GAMMA_LSB +: GREEK_SIZE];
  assign mu          = io_Memory_Data[MU_LSB +: GREEK_SIZE];
  assign cfg_err     = (gamma == '0) || (mu == '0);
  assign cfg_capture = (state_q == ST_READ_CFG) && i_Grant && rd_q;
  // ready_vec shifts out to zero once k reaches P, so no out-of-range select
  assign ready_vec   = P'(1) << k_q;
  assign round_end   = (k_q == KW'(P)) || (remaining == '0);
  assign accept      = (state_q == ST_DISPATCH) && !round_end &&
                       ((i_Indexes_Received & ready_vec) != '0);
  assign all_ready   = ((i_Result_Ready & mask_q) == mask_q);

  block_index_gen #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .GREEK_SIZE  (GREEK_SIZE)
  ) u_index_gen (
    .clk_i       (i_Clock),
    .rst_ni      (i_Reset_n),
    .load_i      (cfg_capture),
    .advance_i   (accept),
    .gamma_i     (gamma),
    .mu_i        (mu),
    .row_o       (o_Row_Index),
    .col_o       (o_Column_Index),
    .remaining_o (remaining)
  );

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q <= ST_IDLE;
      rd_q    <= 1'b0;
      k_q     <= '0;
      mask_q  <= '0;
      cfg_q   <= '0;
      stat_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      k_q     <= k_d;
      mask_q  <= mask_d;
      cfg_q   <= cfg_d;
      stat_q  <= stat_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    k_d     = k_q;
    mask_d  = mask_q;
    cfg_d   = cfg_q;
    stat_d  = stat_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (i_Data_Ready) begin
        state_d = ST_REQ_CFG;
        err_d   = 1'b0;
      end
      ST_REQ_CFG: if (i_Grant) begin
        state_d = ST_READ_CFG;
        rd_d    = 1'b0;
      end
      ST_READ_CFG: begin
        if (!i_Grant) begin
          state_d = ST_REQ_CFG;
          rd_d    = 1'b0;
        end else if (!rd_q) begin
          rd_d = 1'b1;
        end else begin
          rd_d    = 1'b0;
          cfg_d   = io_Memory_Data;
          k_d     = '0;
          mask_d  = '0;
          err_d   = cfg_err;
          state_d = cfg_err ? ST_REQ_STAT : ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        if (round_end) begin
          state_d = ST_WAIT;
        end else if (accept) begin
          k_d    = k_q + KW'(1);
          mask_d = mask_q | ready_vec;
        end
      end
      ST_WAIT: if (all_ready) begin
        if (remaining != '0) begin
          state_d = ST_DISPATCH;
          k_d     = '0;
          mask_d  = '0;
        end else begin
          state_d = ST_REQ_STAT;
        end
      end
      ST_REQ_STAT: if (i_Grant) begin
        state_d = ST_READ_STAT;
        rd_d    = 1'b0;
      end
      ST_READ_STAT: begin
        if (!i_Grant) begin
          state_d = ST_REQ_STAT;
          rd_d    = 1'b0;
        end else if (!rd_q) begin
          rd_d = 1'b1;
        end else begin
          rd_d    = 1'b0;
          stat_d  = io_Memory_Data;
          state_d = ST_WRITE_STAT;
        end
      end
      ST_WRITE_STAT: begin
        if (!i_Grant) begin
          state_d = ST_REQ_STAT;
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_Grant_Request  = 1'b0;
    o_Memory_Address = '0;
    o_Indexes_Ready  = '0;
    o_Write_Enable   = 1'b0;
    stat_word        = stat_q;
    stat_word[STAT_ERR_BIT]  = err_q;
    stat_word[STAT_DONE_BIT] = 1'b1;
    case (state_q)
      ST_REQ_CFG, ST_READ_CFG: begin
        o_Grant_Request  = 1'b1;
        o_Memory_Address = MEMORY_SIZE_LOG'(CONFIG_ADDR);
      end
      ST_REQ_STAT, ST_READ_STAT: begin
        o_Grant_Request  = 1'b1;
        o_Memory_Address = MEMORY_SIZE_LOG'(STATUS_ADDR);
      end
      ST_WRITE_STAT: begin
        o_Grant_Request  = 1'b1;
        o_Memory_Address = MEMORY_SIZE_LOG'(STATUS_ADDR);
        o_Write_Enable   = i_Grant;
      end
      ST_DISPATCH: o_Indexes_Ready = round_end ? '0 : ready_vec;
      default: ;
    endcase
  end

  assign io_Memory_Data = o_Write_Enable ? stat_word : 'z;
  assign o_Config       = cfg_q;
  assign o_Busy         = (state_q != ST_IDLE);
  assign o_Done         = done_q;

endmodule

// File: tb/tb_block_dispatch_cu.sv
// Directed bench for block_dispatch_cu: a memory model on the shared bus,
// grant tied to the request, and PE handshakes driven step by step.
module tb_block_dispatch_cu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        data_ready;
  logic        grant_en;
  logic        grant;
  wire  [31:0] mem_bus;
  logic        grant_req;
  logic [9:0]  addr;
  logic        we;
  logic [31:0] cfg_out;
  logic [7:0]  row, col;
  logic [3:0]  idx_ready, idx_recv, res_ready;
  logic        busy, done;

  logic [31:0] cfg_word, stat_word;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          wr_cnt = 0;
  int          exp_wr = 0;
  int          exp_row, exp_col, gamma_m;

  always #5 clk = ~clk;

  assign grant   = grant_en & grant_req;
  assign mem_bus = we ? 'z : ((addr == 10'd0) ? cfg_word : stat_word);

  always @(posedge clk) if (we) wr_cnt <= wr_cnt + 1;

  block_dispatch_cu #(
    .P               (4),
    .INDEX_WIDTH     (8),
    .GREEK_SIZE      (8),
    .MEMORY_SIZE_LOG (10),
    .CONFIG_ADDR     (0),
    .STATUS_ADDR     (1)
  ) dut (
    .i_Clock            (clk),
    .i_Reset_n          (rst_n),
    .i_Data_Ready       (data_ready),
    .i_Grant            (grant),
    .io_Memory_Data     (mem_bus),
    .o_Grant_Request    (grant_req),
    .o_Memory_Address   (addr),
    .o_Write_Enable     (we),
    .o_Config           (cfg_out),
    .o_Row_Index        (row),
    .o_Column_Index     (col),
    .o_Indexes_Ready    (idx_ready),
    .i_Indexes_Received (idx_recv),
    .i_Result_Ready     (res_ready),
    .o_Busy             (busy),
    .o_Done             (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic reset_outputs_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_greq"}, grant_req, 0);
    chk({tag, "_we"}, we, 0);
    chk({tag, "_rdy"}, idx_ready, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_cfg"}, cfg_out, 0);
    chk({tag, "_row"}, row, 0);
    chk({tag, "_col"}, col, 0);
  endtask

  // Start a job and run the config read; leaves the bench just after capture.
  task automatic do_config(input logic [31:0] cfg, input int gam);
    cfg_word   = cfg;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    chk("cfg_greq", grant_req, 1);
    chk("cfg_addr", addr, 0);
    chk("cfg_busy", busy, 1);
    tick();
    tick();
    tick();
    chk("cfg_word", cfg_out, cfg);
    exp_row = 0;
    exp_col = 0;
    gamma_m = gam;
  endtask

  task automatic accept_pe(input int k);
    logic [3:0] onehot;
    onehot = 4'b0001 << k;
    chk("disp_rdy", idx_ready, onehot);
    chk("disp_row", row, exp_row);
    chk("disp_col", col, exp_col);
    idx_recv = onehot;
    tick();
    idx_recv = '0;
    if (exp_row == gamma_m - 1) begin
      exp_row = 0;
      exp_col++;
    end else begin
      exp_row++;
    end
  endtask

  // Entered with the DUT in REQ_STAT and grant following the request.
  task automatic do_status(input logic [31:0] exp_word);
    chk("stat_greq", grant_req, 1);
    chk("stat_addr", addr, 1);
    tick();
    tick();
    tick();
    chk("wr_we", we, 1);
    chk("wr_addr", addr, 1);
    chk("wr_data", mem_bus, exp_word);
    tick();
    exp_wr++;
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_we", we, 0);
    chk("end_wrcnt", wr_cnt, exp_wr);
    tick();
    chk("end_done_pulse", done, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    data_ready = 1'b0;
    grant_en   = 1'b1;
    idx_recv   = '0;
    res_ready  = '0;
    cfg_word   = '0;
    stat_word  = '0;
    #2;
    reset_outputs_zero("rst");
    tick();
    rst_n = 1'b1;
    tick();

    // Gamma=2, Mu=2: one full round, PE1 handshake held off for 5 cycles
    do_config(32'h0002_0205, 2);
    accept_pe(0);
    idx_recv = 4'b1101;
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      chk("hold_row", row, 1);
      chk("hold_col", col, 0);
      chk("hold_rdy", idx_ready, 4'b0010);
    end
    idx_recv = '0;
    accept_pe(1);
    accept_pe(2);
    accept_pe(3);
    chk("r1_end_rdy", idx_ready, 0);
    tick();
    tick();
    chk("wait_greq", grant_req, 0);
    chk("wait_busy", busy, 1);
    res_ready = 4'b1111;
    tick();
    res_ready = '0;
    do_status(32'h0000_0001);

    // Gamma=3, Mu=2: full round then a partial round of two
    stat_word = 32'hABCD_0000;
    do_config(32'h0002_0300, 3);
    for (int k = 0; k < 4; k++) accept_pe(k);
    chk("g3_r1_end", idx_ready, 0);
    tick();
    res_ready = 4'b1111;
    tick();
    res_ready = '0;
    idx_recv  = 4'b1110;
    tick();
    idx_recv  = '0;
    chk("ign_row", row, 1);
    chk("ign_col", col, 1);
    accept_pe(0);
    accept_pe(1);
    chk("g3_r2_end", idx_ready, 0);
    tick();
    res_ready = 4'b0001;
    tick();
    chk("partial_wait", grant_req, 0);
    res_ready = 4'b0011;
    tick();
    res_ready = '0;
    do_status(32'hABCD_0001);

    // Gamma=0: no dispatch, error bit in the status word
    stat_word = '0;
    do_config(32'h0005_0007, 1);
    chk("err_rdy", idx_ready, 0);
    do_status(32'h0000_0003);

    // Grant lost on the second config read cycle, then retried
    cfg_word   = 32'h0001_0203;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    tick();
    tick();
    grant_en = 1'b0;
    tick();
    chk("drop_cfg", cfg_out, 32'h0005_0007);
    chk("drop_greq", grant_req, 1);
    tick();
    grant_en = 1'b1;
    tick();
    tick();
    tick();
    chk("regrant_cfg", cfg_out, 32'h0001_0203);
    exp_row = 0;
    exp_col = 0;
    gamma_m = 2;
    accept_pe(0);

    // Asynchronous reset in the middle of dispatch
    chk("pre_rst_row", row, 1);
    rst_n = 1'b0;
    #1;
    reset_outputs_zero("midrst");
    #2;
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_wrcnt", wr_cnt, exp_wr);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/block_dispatch_cu.md
BLOCK_DISPATCH_CU -- requirements
Module: block_dispatch_cu

Interface
REQ-001 Parameter P, default 4: number of processing elements served.
REQ-002 Parameter INDEX_WIDTH, default 8: width of row and column indexes.
REQ-003 Parameter GREEK_SIZE, default 8: width of each config field (Lambda, Gamma, Mu).
REQ-004 Parameter MEMORY_SIZE_LOG, default 10: memory address width.
REQ-005 Parameter CONFIG_ADDR, default 0; parameter STATUS_ADDR, default 1.
REQ-006 One clock; reset is asynchronous and active-low.
REQ-007 i_Clock  in  1  rising-edge clock for all state.
REQ-008 i_Reset_n  in  1  asynchronous active-low reset.
REQ-009 i_Data_Ready  in  1  memory status flags a new job.
REQ-010 i_Grant  in  1  memory bus granted to this block.
REQ-011 io_Memory_Data  inout  32  shared data bus, driven only while writing.
REQ-012 o_Grant_Request  out  1  bus request.
REQ-013 o_Memory_Address  out  MEMORY_SIZE_LOG  bus address.
REQ-014 o_Write_Enable  out  1  single-cycle memory write strobe.
REQ-015 o_Config  out  32  last captured config word.
REQ-016 o_Row_Index, o_Column_Index  out  INDEX_WIDTH  block index being dispatched.
REQ-017 o_Indexes_Ready  out  P  one-hot: index valid for PE k.
REQ-018 i_Indexes_Received  in  P  PE k accepted the index.
REQ-019 i_Result_Ready  in  P  PE k finished its block (level).
REQ-020 o_Busy  out  1  high outside IDLE; o_Done  out  1  one-cycle pulse at job end.

Function
REQ-021 States: IDLE, REQ_CFG, READ_CFG, DISPATCH, WAIT, REQ_STAT, READ_STAT, WRITE_STAT.
REQ-022 IDLE -> REQ_CFG when i_Data_Ready=1; o_Grant_Request asserts the same edge.
REQ-023 REQ_CFG -> READ_CFG on i_Grant=1, address CONFIG_ADDR; the bus is not driven.
REQ-024 READ_CFG takes 2 cycles: the address is held, then data is captured on the second edge.
REQ-025 Capture: Lambda=[7:0], Gamma=[15:8], Mu=[23:16] (GREEK_SIZE fields); o_Config is the full word.
REQ-026 Block total N=Gamma*Mu, computed at 2*GREEK_SIZE bits; the remaining-block counter is loaded with N.
REQ-027 If Gamma=0 or Mu=0 -> REQ_STAT with error flag set, no dispatch.
REQ-028 Grant is released (o_Grant_Request=0) on leaving READ_CFG.
REQ-029 DISPATCH: present the index to PE k (k from 0) with o_Indexes_Ready=1<<k; row and column are held stable until i_Indexes_Received[k]=1.
REQ-030 On accept: k+1, remaining-1, row+1; if row==Gamma-1 then row=0 and column+1.
REQ-031 Round ends when k==P or remaining==0; o_Indexes_Ready=0 -> WAIT; the active mask records the PEs used.
REQ-032 i_Indexes_Received bits other than bit k are ignored.
REQ-033 WAIT -> DISPATCH (k=0) when (i_Result_Ready & mask)==mask and remaining>0.
REQ-034 WAIT -> REQ_STAT when (i_Result_Ready & mask)==mask and remaining==0; partial last rounds only wait on the masked PEs.
REQ-035 REQ_STAT: assert o_Grant_Request; on i_Grant go to READ_STAT at STATUS_ADDR; READ_STAT is a 2-cycle read like READ_CFG.
REQ-036 WRITE_STAT drives {read[31:2], error, 1'b1} for one cycle with o_Write_Enable=1.
REQ-037 After WRITE_STAT: release the bus, pulse o_Done, then -> IDLE.
REQ-038 i_Grant dropping in READ_CFG, READ_STAT or WRITE_STAT: go back to the matching REQ state, o_Write_Enable=0, and retry the access from its start.
REQ-039 i_Indexes_Received and i_Result_Ready high in the same cycle: both are honoured independently.
REQ-040 The bus is released (Z) in every state except WRITE_STAT.

Reset
REQ-041 i_Reset_n=0, asynchronously: state=IDLE; all counters, mask, row, column and o_Config=0.
REQ-042 Reset outputs: o_Grant_Request, o_Write_Enable, o_Indexes_Ready, o_Done, o_Busy =0; o_Memory_Address=0; bus=Z.
REQ-043 Reset mid-job abandons the job with no status write.

Structure
REQ-044 A shared package holds the state encoding, config field offsets, CONFIG_ADDR/STATUS_ADDR defaults and status bit positions.
REQ-045 One sub-module, block_index_gen, holds the row/column counter with wrap at Gamma-1 and the remaining-block count.

Verification
REQ-046 P=4, Gamma=2, Mu=2: indexes (0,0),(1,0),(0,1),(1,1) go to PE0..3; one WAIT; status word 0 -> 0x1; o_Done pulse.
REQ-047 P=4, Gamma=3, Mu=2: round 2 dispatches 2 blocks with mask=0011; WAIT exits with only PE0/1 ready.
REQ-048 Gamma=0 -> no o_Indexes_Ready; status written as 0x3.
REQ-049 i_Grant drops on the second READ_CFG cycle -> REQ_CFG; re-grant -> correct capture.
REQ-050 i_Indexes_Received[k] is delayed 5 cycles -> row and column stay stable for those cycles, then advance by one.
REQ-051 i_Reset_n pulsed low during DISPATCH -> all outputs reach reset values immediately; no write; IDLE.
